// File: rtl/temp_sched_pkg.sv
// Shared types and helpers for the round-robin temperature sampling scheduler.
package temp_sched_pkg;

    typedef enum logic [1:0] {IDLE, REQ, OUT, NEXT} state_t;

    localparam int DEF_DATA_W = 8;

    function automatic int chan_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/temp_period_timer.sv
// Free-running period timer: one-cycle tick every PERIOD cycles while enabled.
module temp_period_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!enable || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/temp_sample_sched.sv
// Polls N_SENS sensors in turn each period and feeds their readings to a shared averager.
module temp_sample_sched
    import temp_sched_pkg::*;
#(
    parameter int N_SENS  = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic [N_SENS-1:0]           sens_req,
    input  logic [N_SENS-1:0]           sens_ack,
    input  logic [N_SENS*DATA_W-1:0]    sens_data,
    output logic                        avg_valid,
    input  logic                        avg_ready,
    output logic [chan_w(N_SENS)-1:0]   avg_chan,
    output logic [DATA_W-1:0]           avg_data,
    output logic                        round_done,
    output logic [N_SENS-1:0]           timeout_err,
    output logic                        overrun,
    input  logic                        err_clr
);

    localparam int CW   = chan_w(N_SENS);
    localparam int WT_W = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST_CH = CW'(N_SENS - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     ch;
    logic [WT_W-1:0]   wcnt;
    logic              tick;
    logic              capture;
    logic              to_set;
    logic              last_ch;
    logic [N_SENS-1:0] ch_onehot;

    temp_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign last_ch   = (ch == LAST_CH);
    assign ch_onehot = {{(N_SENS-1){1'b0}}, 1'b1} << ch;

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        to_set     = 1'b0;
        round_done = 1'b0;
        sens_req   = '0;
        avg_valid  = 1'b0;
        case (state)
            IDLE: if (tick) state_nxt = REQ;
            REQ: begin
                sens_req = ch_onehot;
                // A late ack on the final wait cycle still counts as an answer.
                if (sens_ack[ch]) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else if (wcnt == WT_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = NEXT;
                end
            end
            OUT: begin
                avg_valid = 1'b1;
                if (avg_ready) state_nxt = NEXT;
            end
            NEXT: begin
                round_done = last_ch;
                state_nxt  = last_ch ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            wcnt        <= '0;
            avg_chan    <= '0;
            avg_data    <= '0;
            timeout_err <= '0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= (state == REQ) ? wcnt + 1'b1 : '0;
            if (state == NEXT)
                ch <= last_ch ? '0 : ch + 1'b1;
            if (capture) begin
                avg_data <= sens_data[ch*DATA_W +: DATA_W];
                avg_chan <= ch;
            end
            // New errors take priority over a coincident clear.
            timeout_err <= (err_clr ? '0 : timeout_err) | (to_set ? ch_onehot : '0);
            overrun     <= (overrun & ~err_clr) | (tick && state != IDLE);
        end
    end

endmodule

// File: tb/tb_temp_sample_sched.sv
// Directed bench for temp_sample_sched: table of sampling rounds plus reset/backpressure/enable corners.
module tb_temp_sample_sched;

    localparam int N = 4, DW = 8, PER = 20, TO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [N-1:0]    sens_req, sens_ack;
    logic [N*DW-1:0] sens_data;
    logic            avg_valid;
    logic            avg_ready = 1'b1;
    logic [1:0]      avg_chan;
    logic [DW-1:0]   avg_data;
    logic            round_done;
    logic [N-1:0]    timeout_err;
    logic            overrun;
    logic            err_clr = 1'b0;

    logic [31:0]       cfg_data  = 32'h40302010;
    logic [3:0][3:0]   cfg_delay = 16'h1111;
    logic [3:0]        cfg_mute  = 4'b0;
    logic [3:0]        cfg_force = 4'b0;

    int total = 0, bad = 0;
    int req_cnt[4] = '{default: 0};
    int rd_cnt = 0;
    logic [9:0] got_q[$];

    typedef struct {
        logic [31:0] data;
        logic [15:0] delay;
        logic [3:0]  mute;
        logic [3:0]  err;
    } vec_t;
    vec_t tbl[5];

    assign sens_data = cfg_data;

    temp_sample_sched #(.N_SENS(N), .DATA_W(DW), .PERIOD(PER), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sens_req(sens_req), .sens_ack(sens_ack), .sens_data(sens_data),
        .avg_valid(avg_valid), .avg_ready(avg_ready), .avg_chan(avg_chan), .avg_data(avg_data),
        .round_done(round_done), .timeout_err(timeout_err), .overrun(overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Sensor model: acks after cfg_delay extra cycles of req; cfg_force acks unconditionally.
    initial begin
        int hold[4];
        hold = '{default: 0};
        sens_ack = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (sens_req[i]) hold[i]++; else hold[i] = 0;
                sens_ack[i] = (sens_req[i] && !cfg_mute[i] && hold[i] > int'(cfg_delay[i])) || cfg_force[i];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (avg_valid && avg_ready) got_q.push_back({avg_chan, avg_data});
            for (int i = 0; i < N; i++) if (sens_req[i]) req_cnt[i]++;
            if (round_done) rd_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_rd(input int base, input int lim, input string nm);
        int n = 0;
        while (rd_cnt == base && n < lim) begin step(); n++; end
        chk(nm, rd_cnt != base, 1);
    endtask

    task automatic wait_req(input logic [3:0] pat, input int lim, input string nm);
        int n = 0;
        while (sens_req !== pat && n < lim) begin step(); n++; end
        chk(nm, sens_req == pat, 1);
    endtask

    function automatic logic [20:0] outs();
        return {sens_req, avg_valid, avg_chan, avg_data, round_done, timeout_err, overrun};
    endfunction

    // Runs one round from IDLE and checks outputs, request lengths and error flags against the model.
    task automatic run_round(input int r, input logic [31:0] data, input logic [15:0] delay,
                             input logic [3:0] mute, input logic [3:0] force_ack, input logic [3:0] exp_err);
        int base_rd, base_q, idx, n_exp, exp_req;
        int base_req[4];
        logic [3:0][3:0] dl;
        logic [9:0] e;
        cfg_data = data; cfg_delay = delay; cfg_mute = mute; cfg_force = force_ack;
        dl = delay;
        base_rd = rd_cnt; base_q = got_q.size();
        for (int i = 0; i < N; i++) base_req[i] = req_cnt[i];
        wait_rd(base_rd, 60, $sformatf("r%0d_round_wait", r));
        n_exp = 0;
        for (int i = 0; i < N; i++) if (!exp_err[i]) n_exp++;
        chk($sformatf("r%0d_nout", r), got_q.size() - base_q, n_exp);
        idx = base_q;
        for (int i = 0; i < N; i++) begin
            if (!exp_err[i]) begin
                e = {2'(i), data[i*8 +: 8]};
                if (idx < got_q.size()) chk($sformatf("r%0d_out%0d", r, i), got_q[idx], e);
                idx++;
            end
            exp_req = exp_err[i] ? TO : (force_ack[i] ? 1 : int'(dl[i]) + 1);
            chk($sformatf("r%0d_reqlen%0d", r, i), req_cnt[i] - base_req[i], exp_req);
        end
        chk($sformatf("r%0d_rdcnt", r), rd_cnt - base_rd, 1);
        chk($sformatf("r%0d_terr", r), timeout_err, exp_err);
        chk($sformatf("r%0d_ovr", r), overrun, 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk($sformatf("r%0d_terr_clr", r), timeout_err, 0);
        cfg_force = 4'b0;
    endtask

    initial begin
        int base_rd, base_q, n, base_sum, sum;
        tbl[0] = '{32'h40302010, 16'h1111, 4'b0000, 4'b0000};
        tbl[1] = '{32'h40302010, 16'h1111, 4'b0010, 4'b0010};
        tbl[2] = '{32'hA55AFF00, 16'h0230, 4'b0000, 4'b0000};
        tbl[3] = '{32'h0F1E2D3C, 16'h4000, 4'b0000, 4'b1000};
        tbl[4] = '{32'h11223344, 16'h0000, 4'b0111, 4'b0111};

        #1 chk("reset_outs", outs(), 0);
        cfg_mute = 4'b0100;
        step(); step();
        rst = 1'b0; enable = 1'b1;
        wait_req(4'b0100, 80, "midreq_reach");
        step();
        rst = 1'b1; #1;
        chk("reset_midreq_outs", outs(), 0);
        step(); step();
        cfg_mute = 4'b0; base_rd = rd_cnt;
        rst = 1'b0;
        n = 0;
        while (sens_req == 4'b0 && n < 40) begin step(); n++; end
        chk("reset_first_req_lat", n, PER);
        chk("reset_first_req_ch", sens_req, 4'b0001);
        wait_rd(base_rd, 60, "reset_round_wait");

        for (int r = 0; r < 5; r++)
            run_round(r, tbl[r].data, tbl[r].delay, tbl[r].mute, 4'b0, tbl[r].err);

        // Backpressure on channel 0 across a tick.
        cfg_data = 32'h40302010; cfg_delay = 16'h1111; cfg_mute = 4'b0;
        base_rd = rd_cnt; base_q = got_q.size();
        avg_ready = 1'b0;
        n = 0;
        while (!avg_valid && n < 60) begin step(); n++; end
        chk("bp_valid", avg_valid, 1);
        for (int k = 0; k < 50; k++) begin
            step();
            chk("bp_hold", {avg_valid, avg_chan, avg_data, sens_req}, {1'b1, 2'd0, 8'h10, 4'b0});
        end
        chk("bp_overrun", overrun, 1);
        chk("bp_no_round", rd_cnt - base_rd, 0);
        avg_ready = 1'b1;
        wait_rd(base_rd, 60, "bp_round_wait");
        chk("bp_nout", got_q.size() - base_q, 4);
        for (int i = 0; i < N && base_q + i < got_q.size(); i++)
            chk($sformatf("bp_out%0d", i), got_q[base_q + i], {2'(i), cfg_data[i*8 +: 8]});
        chk("bp_rdcnt", rd_cnt - base_rd, 1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("bp_ovr_clr", overrun, 0);

        // enable dropped mid-round.
        base_rd = rd_cnt; base_q = got_q.size();
        wait_req(4'b0100, 60, "en_reach_ch2");
        enable = 1'b0;
        wait_rd(base_rd, 60, "en_round_wait");
        chk("en_nout", got_q.size() - base_q, 4);
        if (got_q.size() >= base_q + 4) begin
            chk("en_out2", got_q[base_q + 2], {2'd2, 8'h30});
            chk("en_out3", got_q[base_q + 3], {2'd3, 8'h40});
        end
        base_sum = 0;
        for (int i = 0; i < N; i++) base_sum += req_cnt[i];
        repeat (100) step();
        sum = 0;
        for (int i = 0; i < N; i++) sum += req_cnt[i];
        chk("en_no_req", sum - base_sum, 0);
        chk("en_no_round", rd_cnt - base_rd, 1);
        enable = 1'b1;

        // Stray ack on channel 3 while channel 0 is being polled.
        run_round(9, 32'h40302010, 16'h0002, 4'b0000, 4'b1000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
